// File: rtl/servo_pulse_decoder.sv
// RC-servo PWM receiver: measures high-time and rising-to-rising period in ticks,
// range-checks the high-time and flags loss of signal. Optional glitch filter: SERVO_DECODER_FILTER_EN.
module servo_pulse_decoder #(
    parameter int unsigned TICK_DIV  = 50,
    parameter int unsigned MIN_WIDTH = 500,
    parameter int unsigned MAX_WIDTH = 2500,
    parameter int unsigned TIMEOUT   = 25000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        pwm_in,
    output logic [11:0] pulse_width,
    output logic [15:0] period,
    output logic        width_valid,
    output logic        range_err,
    output logic        signal_lost
);

    localparam int unsigned PW_W    = 12;
    localparam int unsigned PER_W   = 16;
    localparam int unsigned PRESC_W = 10;
    localparam int unsigned IDLE_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_HIGH,
        ST_LOW
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         sync_q;
    logic               s_q;
    logic               s_c;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PW_W-1:0]    width_cnt_q, width_cnt_d;
    logic [PER_W-1:0]   period_cnt_q, period_cnt_d;
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [PW_W-1:0]    pulse_width_q, pulse_width_d;
    logic [PER_W-1:0]   period_q, period_d;
    logic               width_valid_q, width_valid_d;
    logic               range_err_q, range_err_d;
    logic               signal_lost_q, signal_lost_d;

    logic               tick;
    logic               rise;
    logic               fall;
    logic               timeout;
    logic               in_range;
    logic [PW_W-1:0]    width_inc;
    logic [PER_W-1:0]   period_inc;
    logic [IDLE_W-1:0]  idle_inc;

`ifdef SERVO_DECODER_FILTER_EN
    logic [1:0] samp_q;
    logic       all_hi;
    logic       all_lo;

    // s follows the input only once three consecutive samples agree
    assign all_hi = &{samp_q, sync_q[1]};
    assign all_lo = ~|{samp_q, sync_q[1]};
    assign s_c    = all_hi ? 1'b1 : (all_lo ? 1'b0 : s_q);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            samp_q <= '1;
        end else begin
            samp_q <= {samp_q[0], sync_q[1]};
        end
    end
`else
    assign s_c = sync_q[1];
`endif

    assign rise       = s_c & ~s_q;
    assign fall       = ~s_c & s_q;
    assign tick       = (presc_q == PRESC_W'(TICK_DIV - 1));
    assign timeout    = (idle_cnt_q >= IDLE_W'(TIMEOUT));
    assign width_inc  = (tick && (width_cnt_q != '1)) ? width_cnt_q + PW_W'(1) : width_cnt_q;
    assign period_inc = (tick && (period_cnt_q != '1)) ? period_cnt_q + PER_W'(1) : period_cnt_q;
    assign idle_inc   = (tick && (idle_cnt_q != '1)) ? idle_cnt_q + IDLE_W'(1) : idle_cnt_q;
    assign in_range   = (width_inc >= PW_W'(MIN_WIDTH)) && (width_inc <= PW_W'(MAX_WIDTH));

    // Synchronizer and edge history reset high so a pin already high at reset is not measured
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q        <= '1;
            s_q           <= 1'b1;
            state_q       <= ST_IDLE;
            presc_q       <= '0;
            width_cnt_q   <= '0;
            period_cnt_q  <= '0;
            idle_cnt_q    <= '0;
            pulse_width_q <= '0;
            period_q      <= '0;
            width_valid_q <= 1'b0;
            range_err_q   <= 1'b0;
            signal_lost_q <= 1'b1;
        end else begin
            sync_q        <= {sync_q[0], pwm_in};
            s_q           <= s_c;
            state_q       <= state_d;
            presc_q       <= presc_d;
            width_cnt_q   <= width_cnt_d;
            period_cnt_q  <= period_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            pulse_width_q <= pulse_width_d;
            period_q      <= period_d;
            width_valid_q <= width_valid_d;
            range_err_q   <= range_err_d;
            signal_lost_q <= signal_lost_d;
        end
    end

    // Captures include the tick of the edge cycle so N*TICK_DIV cycles read exactly N
    always_comb begin
        state_d       = state_q;
        presc_d       = tick ? '0 : presc_q + PRESC_W'(1);
        width_cnt_d   = width_inc;
        period_cnt_d  = period_inc;
        idle_cnt_d    = idle_inc;
        pulse_width_d = pulse_width_q;
        period_d      = period_q;
        width_valid_d = 1'b0;
        range_err_d   = 1'b0;
        signal_lost_d = signal_lost_q;

        if (rise) begin
            presc_d      = '0;
            width_cnt_d  = '0;
            period_cnt_d = '0;
        end
        if (rise || fall) begin
            idle_cnt_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!s_c) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (rise) begin
                    state_d = ST_HIGH;
                end else if (timeout) begin
                    signal_lost_d = 1'b1;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    state_d = ST_LOW;
                    if (in_range) begin
                        pulse_width_d = width_inc;
                        width_valid_d = 1'b1;
                        signal_lost_d = 1'b0;
                    end else begin
                        range_err_d = 1'b1;
                    end
                end else if (timeout) begin
                    signal_lost_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    period_d = period_inc;
                    state_d  = ST_HIGH;
                end else if (timeout) begin
                    signal_lost_d = 1'b1;
                    state_d       = ST_ARMED;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pulse_width = pulse_width_q;
    assign period      = period_q;
    assign width_valid = width_valid_q;
    assign range_err   = range_err_q;
    assign signal_lost = signal_lost_q;

endmodule
